// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pkg
//  Description : Shared constants and types for the response transmitter.
//                Frame-type codes, the MATCH header byte, frame lengths and
//                the transmitter state encoding.
//  Macros      : RESP_CHECKSUM_EN - frame lengths include a trailing
//                XOR checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package md5_pkg;

    // req_type encodings
    localparam logic c_FT_ACK   = 1'b0;
    localparam logic c_FT_MATCH = 1'b1;

    // First byte of every MATCH frame
    localparam logic [7:0] c_MATCH_HDR = 8'h03;

    // Payload bytes held in the shift register for a MATCH frame:
    // header + 2 position bytes + 16 digest bytes.
    localparam int c_MATCH_DATA_BYTES = 19;
    localparam int c_SHIFT_W          = 8 * c_MATCH_DATA_BYTES;

`ifdef RESP_CHECKSUM_EN
    localparam logic [4:0] c_ACK_LEN   = 5'd2;
    localparam logic [4:0] c_MATCH_LEN = 5'd20;
`else
    localparam logic [4:0] c_ACK_LEN   = 5'd1;
    localparam logic [4:0] c_MATCH_LEN = 5'd19;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

endpackage : md5_pkg
`default_nettype wire

// File: rtl/resp_tx.sv
`default_nettype none
// ============================================================================
//  Module      : resp_tx
//  Description : Serialises ACK (1 byte) and MATCH (19 byte) response frames
//                onto a byte-wide UART transmitter interface, pacing bytes
//                by the transmitter busy flag plus GAP_CYCLES idle clocks.
//  Macros      : RESP_CHECKSUM_EN - append an XOR checksum byte per frame.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                req_valid/ready   - request handshake (ready only in IDLE)
//                req_type/code/pos/hash - request fields
//                txd_busy          - transmitter busy flag
//                txd_start/data    - one-clock byte launch, data 0 otherwise
//                frame_done        - pulse one clock after last byte launch
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_tx
    import md5_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_type,
    input  logic [7:0]   req_code,
    input  logic [15:0]  req_pos,
    input  logic [127:0] req_hash,
    input  logic         txd_busy,
    output logic         txd_start,
    output logic [7:0]   txd_data,
    output logic         frame_done
);

    localparam logic [3:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t               state_q;
    state_t               state_d;
    state_t               w_after_wait;
    logic [4:0]           cnt_q;
    logic [c_SHIFT_W-1:0] shift_q;
    logic [3:0]           gap_q;
    logic                 ready_en_q;
    logic                 frame_done_q;
    logic                 w_accept;
    logic                 w_launch;
    logic                 w_last;
    logic [7:0]           w_byte;

    // ready_en_q holds req_ready low until the first clock after reset release
    assign req_ready  = ready_en_q && (state_q == ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_launch   = (state_q == ST_SEND) && !txd_busy;
    assign w_last     = (cnt_q == 5'd1);

`ifdef RESP_CHECKSUM_EN
    logic [7:0] csum_q;

    // The final byte of a frame is the running XOR of all bytes before it
    assign w_byte = w_last ? csum_q : shift_q[c_SHIFT_W-1 -: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else if (w_accept) begin
            csum_q <= 8'h00;
        end else if (w_launch) begin
            csum_q <= csum_q ^ w_byte;
        end
    end
`else
    assign w_byte = shift_q[c_SHIFT_W-1 -: 8];
`endif

    assign txd_start  = w_launch;
    assign txd_data   = w_launch ? w_byte : 8'h00;
    assign frame_done = frame_done_q;

    // Destination once the current byte has cleared the transmitter
    assign w_after_wait = (cnt_q != 5'd0) ? ST_SEND : ST_IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (w_launch) state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!txd_busy) state_d = (GAP_CYCLES > 0) ? ST_GAP : w_after_wait;
            end
            ST_GAP: begin
                if (gap_q == 4'd0) state_d = w_after_wait;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            shift_q      <= '0;
            gap_q        <= 4'd0;
            ready_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            frame_done_q <= w_launch && w_last;

            if (w_accept) begin
                // Bytes leave MSB-first, so frames are left-aligned
                if (req_type == c_FT_MATCH) begin
                    shift_q <= {c_MATCH_HDR, req_pos, req_hash};
                    cnt_q   <= c_MATCH_LEN;
                end else begin
                    shift_q <= {req_code, {(c_SHIFT_W-8){1'b0}}};
                    cnt_q   <= c_ACK_LEN;
                end
            end else if (w_launch) begin
                shift_q <= {shift_q[c_SHIFT_W-9:0], 8'h00};
                cnt_q   <= cnt_q - 5'd1;
            end

            // Gap counter is primed while waiting so GAP lasts GAP_CYCLES clocks
            if (state_q == ST_WAIT_BUSY) begin
                gap_q <= c_GAP_LOAD;
            end else if ((state_q == ST_GAP) && (gap_q != 4'd0)) begin
                gap_q <= gap_q - 4'd1;
            end
        end
    end

endmodule : resp_tx
`default_nettype wire

// File: tb/tb_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resp_tx
//  Description : Self-checking bench for resp_tx. A reference model builds
//                the expected byte list of each frame; a monitor records
//                every launched byte and its cycle number.
//  Macros      : RESP_CHECKSUM_EN - expected frames carry an XOR byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_tx;

    localparam int GAP = 1;
    localparam logic [127:0] c_REF_HASH = 128'ha2004f37730b9445670a738fa0fc9ee5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_type;
    logic [7:0]   req_code;
    logic [15:0]  req_pos;
    logic [127:0] req_hash;
    logic         txd_busy;
    logic         txd_start;
    logic [7:0]   txd_data;
    logic         frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int idle_bad = 0;

    byte unsigned mon_b[$];
    int           mon_c[$];
    int           fd_c[$];
    byte unsigned exp_b[$];

    resp_tx #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_code   (req_code),
        .req_pos    (req_pos),
        .req_hash   (req_hash),
        .txd_busy   (txd_busy),
        .txd_start  (txd_start),
        .txd_data   (txd_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Launches are sampled mid-cycle, tagged with the cycle they occupy
    always @(negedge clk) begin
        if (txd_start === 1'b1) begin
            mon_b.push_back(txd_data);
            mon_c.push_back(cyc);
        end else if (txd_data !== 8'h00) begin
            idle_bad++;
        end
        if (frame_done === 1'b1) fd_c.push_back(cyc);
    end

    // Reference frame: list of bytes in wire order
    function automatic void build_exp(input logic t, input logic [7:0] code,
                                      input logic [15:0] pos, input logic [127:0] h);
        byte unsigned x;
        exp_b.delete();
        if (t == 1'b0) begin
            exp_b.push_back(code);
        end else begin
            exp_b.push_back(8'h03);
            exp_b.push_back(8'(pos / 256));
            exp_b.push_back(8'(pos % 256));
            for (int i = 15; i >= 0; i--) exp_b.push_back(8'(h >> (8 * i)));
        end
`ifdef RESP_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_b[i]) x = x ^ exp_b[i];
        exp_b.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mon_b.delete();
        mon_c.delete();
        fd_c.delete();
    endtask

    // Offer one request in IDLE; acc is the cycle the first byte should occupy
    task automatic send_req(input logic t, input logic [7:0] code, input logic [15:0] pos,
                            input logic [127:0] h, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (req_ready === 1'b1) begin
                req_valid = 1'b1;
                req_type  = t;
                req_code  = code;
                req_pos   = pos;
                req_hash  = h;
                tick();
                req_valid = 1'b0;
                acc = cyc;
                ok  = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_bytes(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (mon_b.size() >= n) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic run_frame(input string nm, input logic t, input logic [7:0] code,
                             input logic [15:0] pos, input logic [127:0] h);
        int acc;
        bit ok;
        build_exp(t, code, pos, h);
        clr();
        send_req(t, code, pos, h, acc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_accept ready never seen, got %0b want 1", nm, req_ready);
            return;
        end
        wait_bytes(exp_b.size(), 600, ok);
        repeat (4) tick();
        checks++;
        if (mon_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL %s_len got %0d bytes want %0d", nm, mon_b.size(), exp_b.size());
        end
        foreach (exp_b[i]) begin
            checks++;
            if (i >= mon_b.size() || mon_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL %s_byte[%0d] got %02h want %02h", nm, i,
                         (i < mon_b.size()) ? mon_b[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++;
        if (mon_c.size() == 0 || mon_c[0] !== acc) begin
            errors++;
            $display("FAIL %s_latency got cycle %0d want %0d", nm,
                     (mon_c.size() > 0) ? mon_c[0] : -1, acc);
        end
        for (int i = 1; i < mon_c.size(); i++) begin
            checks++;
            if (mon_c[i] - mon_c[i-1] !== 2 + GAP) begin
                errors++;
                $display("FAIL %s_spacing[%0d] got %0d want %0d", nm, i,
                         mon_c[i] - mon_c[i-1], 2 + GAP);
            end
        end
        checks++;
        if (fd_c.size() != 1 || mon_c.size() == 0 || fd_c[0] !== mon_c[$] + 1) begin
            errors++;
            $display("FAIL %s_frame_done got %0d pulses first at %0d want 1 at %0d", nm,
                     fd_c.size(), (fd_c.size() > 0) ? fd_c[0] : -1,
                     (mon_c.size() > 0) ? mon_c[$] + 1 : -1);
        end
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || txd_start !== 1'b0 || txd_data !== 8'h00 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b start=%b data=%02h done=%b want 0 0 00 0",
                     req_ready, txd_start, txd_data, frame_done);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early got %b want 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise got %b want 1", req_ready);
        end
    endtask

    task automatic test_ack();
        run_frame("ack", 1'b0, 8'h01, 16'h0000, 128'h0);
`ifdef RESP_CHECKSUM_EN
        run_frame("ack_csum", 1'b0, 8'h02, 16'h0000, 128'h0);
`endif
    endtask

    task automatic test_match();
        run_frame("match", 1'b1, 8'h00, 16'h0004, c_REF_HASH);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic         t;
            logic [7:0]   code;
            logic [15:0]  pos;
            logic [127:0] h;
            t    = 1'($urandom_range(0, 1));
            code = 8'($urandom);
            pos  = 16'($urandom);
            h    = {$urandom, $urandom, $urandom, $urandom};
            run_frame("random", t, code, pos, h);
        end
    endtask

    task automatic test_backpressure();
        int acc, n0, n1, rel;
        bit ok;
        build_exp(1'b1, 8'h00, 16'h0004, c_REF_HASH);
        clr();
        send_req(1'b1, 8'h00, 16'h0004, c_REF_HASH, acc, ok);
        wait_bytes(5, 100, ok);
        txd_busy = 1'b1;
        n0 = mon_b.size();
        repeat (50) tick();
        n1  = mon_b.size();
        rel = cyc;
        txd_busy = 1'b0;
        checks++;
        if (!ok || n1 !== n0) begin
            errors++;
            $display("FAIL bp_hold got %0d bytes after hold want %0d", n1, n0);
        end
        wait_bytes(exp_b.size(), 600, ok);
        repeat (4) tick();
        checks++;
        if (mon_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL bp_len got %0d want %0d", mon_b.size(), exp_b.size());
        end
        foreach (exp_b[i]) begin
            checks++;
            if (i >= mon_b.size() || mon_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL bp_byte[%0d] got %02h want %02h", i,
                         (i < mon_b.size()) ? mon_b[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++;
        if (mon_c.size() <= n0 || mon_c[n0] < rel) begin
            errors++;
            $display("FAIL bp_resume got cycle %0d want >= %0d",
                     (mon_c.size() > n0) ? mon_c[n0] : -1, rel);
        end
    endtask

    task automatic test_accept();
        int acc;
        bit ok;
        build_exp(1'b1, 8'h00, 16'h1234, c_REF_HASH);
        clr();
        send_req(1'b1, 8'h00, 16'h1234, c_REF_HASH, acc, ok);
        wait_bytes(3, 100, ok);
        req_type  = 1'b0;
        req_code  = 8'h55;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL acc_busy_ready[%0d] got %b want 0", i, req_ready);
            end
            tick();
        end
        req_valid = 1'b0;
        wait_bytes(exp_b.size(), 600, ok);
        repeat (10) tick();
        checks++;
        if (mon_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL acc_ignored got %0d bytes want %0d", mon_b.size(), exp_b.size());
        end
        run_frame("acc_reoffer", 1'b0, 8'h55, 16'h0000, 128'h0);
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        bit found;
        build_exp(1'b1, 8'h00, 16'h0004, c_REF_HASH);
        clr();
        send_req(1'b1, 8'h00, 16'h0004, c_REF_HASH, acc, ok);
        wait_bytes(5, 100, ok);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (txd_start === 1'b1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_sixth_pulse got none want txd_start=1");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (txd_start !== 1'b0 || txd_data !== 8'h00 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate got start=%b data=%02h ready=%b want 0 00 0",
                     txd_start, txd_data, req_ready);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_early got %b want 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_rise got %b want 1", req_ready);
        end
        repeat (30) tick();
        checks++;
        if (mon_b.size() != 5 || fd_c.size() != 0) begin
            errors++;
            $display("FAIL rst_abandon got %0d bytes %0d done want 5 bytes 0 done",
                     mon_b.size(), fd_c.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= mon_b.size() || mon_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL rst_byte[%0d] got %02h want %02h", i,
                         (i < mon_b.size()) ? mon_b[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_idle_data();
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL idle_data got %0d nonzero samples want 0", idle_bad);
        end
    endtask

    initial begin
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_type  = 1'b0;
        req_code  = 8'h00;
        req_pos   = 16'h0000;
        req_hash  = 128'h0;
        txd_busy  = 1'b0;
        test_reset();
        test_ack();
        test_match();
        test_random();
        test_backpressure();
        test_accept();
        test_reset_mid();
        test_idle_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_resp_tx
`default_nettype wire
